// File: rtl/uart_tx_serializer.sv
// 8N1 (optionally 8E1/8O1) UART transmit serializer clocked by the 16x oversample clock.
// Optional parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk16x,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 char_complete_tx
);

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(DATA_BITS + STOP_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // Reject configurations the frame logic is not built for.
    if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        DATA_BITS < 1 || OVERSAMPLE < 2) begin : g_bad_cfg
        $error("uart_tx_serializer: unsupported parameter combination");
    end

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    always_ff @(posedge clk16x or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            bit_idx          <= '0;
            shift            <= '0;
            tx               <= 1'b1;
            tx_busy          <= 1'b0;
            char_complete_tx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit          <= 1'b0;
`endif
        end else begin
            char_complete_tx <= 1'b0;
            if (state == S_IDLE) begin
                tx <= 1'b1;
                if (load) begin
                    shift   <= data_in;
                    state   <= S_START;
                    tx      <= 1'b0;
                    tx_busy <= 1'b1;
                    cnt     <= '0;
                    bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                    // Parity comes from the latched byte; the shifter is consumed by then.
                    par_bit <= (^data_in) ^ (PARITY_ODD != 0);
`endif
                end
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                // Bit boundary: tx takes the value of the next bit on this edge.
                cnt <= '0;
                case (state)
                    S_START: begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                    end
                    S_DATA: begin
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= S_PARITY;
                            tx      <= par_bit;
`else
                            state   <= S_STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        state   <= S_STOP;
                        bit_idx <= '0;
                        tx      <= 1'b1;
                    end
`endif
                    S_STOP: begin
                        tx <= 1'b1;
                        if (bit_idx == STOP_LAST) begin
                            state            <= S_IDLE;
                            bit_idx          <= '0;
                            tx_busy          <= 1'b0;
                            char_complete_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench for uart_tx_serializer against a frame-level queue model of the line.
// Define UART_TX_PARITY_EN for both files to exercise the parity frame.
module tb_uart_tx_serializer;

    localparam int DB   = 8;
    localparam int OS   = 16;
    localparam int SB   = 1;
    localparam int PODD = 0;

    logic          clk16x  = 1'b0;
    logic          reset   = 1'b1;
    logic          load    = 1'b0;
    logic [DB-1:0] data_in = '0;
    logic          tx, tx_busy, char_complete_tx;

    uart_tx_serializer #(
        .DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB), .PARITY_ODD(PODD)
    ) dut (
        .clk16x(clk16x), .reset(reset), .data_in(data_in), .load(load),
        .tx(tx), .tx_busy(tx_busy), .char_complete_tx(char_complete_tx)
    );

    always #5 clk16x = ~clk16x;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: one entry {tx, busy, done} per future clock edge of the current frame.
    logic [2:0] mq[$];
    logic [2:0] cur = 3'b100;
    int         model_done = 0;
    int         dut_done   = 0;
    int         dut_done_total = 0;

    function automatic void build_frame(input logic [DB-1:0] d);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back((^d) ^ (PODD != 0));
`endif
        for (int i = 0; i < SB; i++) bits.push_back(1'b1);
        foreach (bits[i])
            for (int s = 0; s < OS; s++) mq.push_back({bits[i], 1'b1, 1'b0});
        mq.push_back(3'b101);
    endfunction

    always @(posedge clk16x or posedge reset) begin
        if (reset) begin
            mq.delete();
            cur <= 3'b100;
        end else begin
            if (mq.size() == 0 && load) build_frame(data_in);
            if (mq.size() != 0) begin
                if (mq[0][0]) model_done++;
                cur <= mq.pop_front();
            end else begin
                cur <= 3'b100;
            end
        end
    end

    always @(negedge clk16x) begin
        if (!reset) begin
            chk("tx", {31'd0, tx}, {31'd0, cur[2]});
            chk("tx_busy", {31'd0, tx_busy}, {31'd0, cur[1]});
            chk("char_complete_tx", {31'd0, char_complete_tx}, {31'd0, cur[0]});
            if (char_complete_tx) begin
                dut_done++;
                dut_done_total++;
            end
        end
    end

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_done", {31'd0, char_complete_tx}, 32'd0);
        @(negedge clk16x) reset = 1'b0;
    endtask

    task automatic send_pulse(input logic [DB-1:0] d);
        data_in = d;
        load    = 1'b1;
        @(negedge clk16x);
        load    = 1'b0;
        data_in = DB'($urandom);
    endtask

    initial begin
        repeat (3) @(negedge clk16x);
        chk("por_tx", {31'd0, tx}, 32'd1);
        chk("por_busy", {31'd0, tx_busy}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk16x);

        // Single byte, with an ignored load mid-frame.
        dut_done = 0;
        send_pulse(8'h43);
        repeat (48) @(negedge clk16x);
        send_pulse(8'hFF);
        repeat (200) @(negedge clk16x);
        chk("single_done_cnt", dut_done, 32'd1);

        // Reset in the middle of data bit 3, then a clean frame.
        dut_done = 0;
        send_pulse(8'h43);
        repeat (69) @(negedge clk16x);
        async_reset_pulse();
        repeat (20) @(negedge clk16x);
        chk("abort_no_done", dut_done, 32'd0);
        send_pulse(8'hA5);
        repeat (200) @(negedge clk16x);
        chk("after_rst_done_cnt", dut_done, 32'd1);

        // Back-to-back with load held high.
        dut_done = 0;
        data_in = 8'h00;
        load    = 1'b1;
        @(negedge clk16x);
        data_in = 8'hFF;
        repeat (165) @(negedge clk16x);
        load = 1'b0;
        repeat (200) @(negedge clk16x);
        chk("b2b_done_cnt", dut_done, 32'd2);

        // Random traffic: random bytes, stray loads, data churn, occasional resets.
        for (int i = 0; i < 25; i++) begin
            data_in = DB'($urandom);
            load    = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk16x);
            load = 1'b0;
            for (int c = 0; c < 180; c++) begin
                @(negedge clk16x);
                load    = ($urandom_range(0, 9) == 0);
                data_in = DB'($urandom);
                if (c == 90 && $urandom_range(0, 7) == 0) async_reset_pulse();
            end
            load = 1'b0;
            repeat ($urandom_range(0, 20)) @(negedge clk16x);
        end
        repeat (200) @(negedge clk16x);
        chk("done_total", dut_done_total, model_done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit half of the 9600 Bps serial link; counterpart to the existing start-bit-detect / bsc / bic / SIPO receive path.
- Accepts a parallel byte from the Nios II parallel-port outputs (`data_out`, `load`).
- Serializes the byte as an 8N1 frame on GPIO_0[1], LSB first.
- Runs entirely on the 16x oversample clock from clock16x and reports frame completion via `char_complete_tx`.

Parameters:
- DATA_BITS, 8: payload bits per frame.
- OVERSAMPLE, 16: clk16x cycles per bit period.
- STOP_BITS, 1: stop bits per frame (1 or 2).
- PARITY_ODD, 0: parity sense, 1 = odd, 0 = even. Used only when UART_TX_PARITY_EN is defined.

Ports:
- clk16x  input  1  16x baud clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_BITS  byte to transmit; sampled only when a load is accepted.
- load  input  1  level request; accepted only in IDLE.
- tx  output  1  serial line (idle high).
- tx_busy  output  1  high from load acceptance until frame end.
- char_complete_tx  output  1  one-cycle pulse at end of frame.

Behaviour:
- **Clocking and reset.**
  - One clock domain: clk16x.
  - Reset is asynchronous and active-high.
  - While reset is high: state = IDLE, tx = 1, tx_busy = 0, char_complete_tx = 0, bit and sample counters = 0, shift register = 0.
- **Registered outputs.** tx, tx_busy and char_complete_tx are registered, so there are no combinational paths from inputs to outputs.
- **States.** IDLE, START, DATA, [PARITY], STOP.
- **IDLE.**
  - tx = 1.
  - On a rising edge with load = 1: latch data_in into the shift register, go to START, set tx_busy = 1.
  - tx = 0 is visible after that same edge, giving a latency of 1 edge from load to the start bit.
- **Bit timing.**
  - Each bit holds tx for exactly OVERSAMPLE edges.
  - The sample counter runs 0..OVERSAMPLE-1 and wraps to 0 on every bit transition.
- **START.** One bit of 0, then go to DATA.
- **DATA.**
  - Sends shift[0], shifting right once per bit, for DATA_BITS bits; bit index 0..DATA_BITS-1.
  - After the last bit, go to STOP, or to PARITY if the option is enabled.
- **STOP.**
  - tx = 1 for STOP_BITS bit periods.
  - At the final edge: go to IDLE, set tx_busy = 0, char_complete_tx = 1 for exactly one cycle.
- **Frame length (8N1, OVERSAMPLE = 16).** Load accepted at edge k:
  - Start bit occupies edges k..k+15.
  - Data bit n begins at edge k+16(n+1).
  - Stop bit occupies edges k+144..k+159.
  - At edge k+160: IDLE, char_complete_tx high until edge k+161.
- **Load while busy.** load = 1 in any non-IDLE state is ignored; no queueing. The latched byte is unaffected by data_in changes mid-frame.
- **Back-to-back frames.**
  - load held high across the end of a frame is accepted on the first IDLE edge (k+161).
  - Minimum frame-to-frame spacing is therefore 161 edges, with one idle-high cycle between frames.
- **Reset mid-frame.** Frame is aborted immediately: tx = 1, no char_complete_tx pulse, state IDLE.
- **Simultaneous events.** reset dominates load.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- **Defined:**
  - Adds a PARITY state between DATA and STOP for one bit period.
  - Parity bit = XOR of the latched byte, inverted when PARITY_ODD = 1.
  - Frame becomes 11 bits: 176 edges for 8 data bits plus 1 stop bit; char_complete_tx at edge k+176.
- **Not defined:** no PARITY state, no parity logic; PARITY_ODD is ignored; 8N1 timing as above.

Test Plan:
1. **Reset values.** Assert reset mid-simulation with no clock edge → tx = 1, tx_busy = 0, char_complete_tx = 0 immediately.
2. **Single byte.** load = 1 for one cycle with data_in = 8'h43 → tx bit sequence, 16 edges each: 0, 1, 1, 0, 0, 0, 0, 1, 0, 1. tx_busy high for edges k..k+159; char_complete_tx single pulse at k+160.
3. **Load while busy.** At edge k+50, load = 1 with data_in = 8'hFF → ignored; the frame still carries 8'h43; no second frame starts.
4. **Reset mid-frame.** Reset at edge k+70 (during data bit 3) → tx = 1 at once, no char_complete_tx. A new load of 8'hA5 after reset produces a clean full frame.
5. **Back-to-back.** Hold load high with 8'h00 then 8'hFF → second start bit begins at edge k+161; exactly one idle-high cycle between frames; two char_complete_tx pulses.
6. **Parity option.** With UART_TX_PARITY_EN defined and PARITY_ODD = 0, send 8'h43 → parity bit = 1, sent at edges k+144..k+159; stop bit at k+160..k+175; char_complete_tx at k+176. With PARITY_ODD = 1 → parity bit = 0.
